// File: rtl/uart_fifo_pkg.sv
// Shared constants for the burst loopback path: burst size, byte width, timeouts,
// one-hot state codes for burst_send_ctrl and the bit positions of its error flags.
package uart_fifo_pkg;

    localparam int BURST_LEN = 256;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = $clog2(BURST_LEN + 1);
    localparam int ACK_TO    = 15;

    localparam int ERR_OVF   = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_ACKTO = 2;
    localparam int ERR_W     = 3;

    localparam logic [7:0] ST_IDLE  = 8'h01;
    localparam logic [7:0] ST_CLR   = 8'h02;
    localparam logic [7:0] ST_FILL  = 8'h04;
    localparam logic [7:0] ST_RD    = 8'h08;
    localparam logic [7:0] ST_LATCH = 8'h10;
    localparam logic [7:0] ST_ACK   = 8'h20;
    localparam logic [7:0] ST_WAIT  = 8'h40;
    localparam logic [7:0] ST_DONE  = 8'h80;

    typedef enum logic [7:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_FILL  = ST_FILL,
        S_RD    = ST_RD,
        S_LATCH = ST_LATCH,
        S_ACK   = ST_ACK,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/burst_send_ctrl_rise_det.sv
// Rising-edge detector: holds last sample in a flop, flags a 0->1 change in the
// current cycle. One cycle of history, no backpressure.
module rise_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/burst_send_ctrl.sv
// Burst sequencer: fills the FIFO from the byte generator, then drains it to the UART TX.
// All outputs registered; drain paced by tx_busy, ack timeout guards a stuck UART.
module burst_send_ctrl #(
    parameter int BURST_LEN = uart_fifo_pkg::BURST_LEN,
    parameter int CNT_W     = uart_fifo_pkg::CNT_W,
    parameter int ACK_TO    = uart_fifo_pkg::ACK_TO
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              gen_en,
    input  logic                              gen_ok,
    input  logic [uart_fifo_pkg::DATA_W-1:0]  gen_data,
    output logic                              fifo_clr,
    output logic                              fifo_wr_en,
    output logic [uart_fifo_pkg::DATA_W-1:0]  fifo_wr_data,
    input  logic                              fifo_full,
    output logic                              fifo_rd_en,
    input  logic [uart_fifo_pkg::DATA_W-1:0]  fifo_rd_data,
    input  logic                              fifo_empty,
    output logic                              tx_start,
    output logic [uart_fifo_pkg::DATA_W-1:0]  tx_data,
    input  logic                              tx_busy,
    output logic                              busy,
    output logic                              done,
    output logic [uart_fifo_pkg::ERR_W-1:0]   err,
    output logic [CNT_W-1:0]                  wr_cnt,
    output logic [CNT_W-1:0]                  sent_cnt
);

    import uart_fifo_pkg::*;

    localparam int              TO_W      = $clog2(ACK_TO + 1);
    localparam logic [CNT_W-1:0] C_LEN     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(BURST_LEN - 1);
    localparam logic [TO_W-1:0]  C_TO_LAST = TO_W'(ACK_TO - 1);

    state_t          r_state;
    logic            r_lat_ph;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_gen_rise;
    logic            w_busy_rise;

    rise_det u_gen_rise (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_sig   (gen_ok),
        .o_rise  (w_gen_rise)
    );

    rise_det u_busy_rise (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_sig   (tx_busy),
        .o_rise  (w_busy_rise)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_lat_ph     <= 1'b0;
            r_to_cnt     <= '0;
            gen_en       <= 1'b0;
            fifo_clr     <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rd_en   <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= '0;
            wr_cnt       <= '0;
            sent_cnt     <= '0;
        end else begin
            fifo_clr   <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_start   <= 1'b0;
            done       <= 1'b0;

            // Abort leaves FIFO contents, counters and err as they are.
            if (abort && (r_state != S_IDLE)) begin
                gen_en  <= 1'b0;
                busy    <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            fifo_clr <= 1'b1;
                            busy     <= 1'b1;
                            wr_cnt   <= '0;
                            sent_cnt <= '0;
                            err      <= '0;
                            r_state  <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        gen_en  <= 1'b1;
                        r_state <= S_FILL;
                    end
                    S_FILL: begin
                        if (w_gen_rise) begin
                            if (fifo_full) begin
                                err[ERR_OVF] <= 1'b1;
                            end else begin
                                fifo_wr_en   <= 1'b1;
                                fifo_wr_data <= gen_data;
                            end
                            if (wr_cnt < C_LEN) begin
                                wr_cnt <= wr_cnt + CNT_W'(1);
                            end
                            // Final byte: generator is released with the last write strobe.
                            if (wr_cnt >= C_LAST) begin
                                gen_en  <= 1'b0;
                                r_state <= S_RD;
                            end
                        end
                    end
                    S_RD: begin
                        if (sent_cnt >= C_LEN) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else if (fifo_empty) begin
                            err[ERR_SHORT] <= 1'b1;
                            done           <= 1'b1;
                            r_state        <= S_DONE;
                        end else if (!tx_busy) begin
                            fifo_rd_en <= 1'b1;
                            r_lat_ph   <= 1'b0;
                            r_state    <= S_LATCH;
                        end
                    end
                    S_LATCH: begin
                        // First cycle carries the read strobe; read data lands a cycle later.
                        if (!r_lat_ph) begin
                            r_lat_ph <= 1'b1;
                        end else begin
                            tx_data  <= fifo_rd_data;
                            tx_start <= 1'b1;
                            if (sent_cnt < C_LEN) begin
                                sent_cnt <= sent_cnt + CNT_W'(1);
                            end
                            r_to_cnt <= '0;
                            r_state  <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (w_busy_rise) begin
                            r_state <= S_WAIT;
                        end else if (r_to_cnt == C_TO_LAST) begin
                            err[ERR_ACKTO] <= 1'b1;
                            done           <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (!tx_busy) begin
                            r_state <= S_RD;
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        gen_en  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_burst_send_ctrl.sv
// Directed bench for burst_send_ctrl with generator, FIFO and UART TX models;
// expected byte sequences and counts are derived by the bench from the stimulus.
module tb_burst_send_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       gen_en;
    logic       gen_ok    = 1'b0;
    logic [7:0] gen_data  = 8'h00;
    logic       fifo_clr;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_full;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy   = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] err;
    logic [8:0] wr_cnt;
    logic [8:0] sent_cnt;

    always #5 sys_clk = ~sys_clk;

    burst_send_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .abort        (abort),
        .gen_en       (gen_en),
        .gen_ok       (gen_ok),
        .gen_data     (gen_data),
        .fifo_clr     (fifo_clr),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .wr_cnt       (wr_cnt),
        .sent_cnt     (sent_cnt)
    );

    // Generator: one byte every 4 cycles, data_ok high for gen_hold cycles.
    int         gen_hold   = 1;
    int         gen_ph     = 0;
    logic [7:0] gen_byte   = 8'h00;
    bit         force_mode = 1'b0;
    logic       force_full = 1'b0;

    always @(posedge sys_clk) begin
        if (fifo_clr) gen_byte <= 8'h00;
        if (!gen_en) begin
            gen_ok     <= 1'b0;
            gen_ph     <= 0;
            force_full <= 1'b0;
        end else begin
            gen_ph <= (gen_ph == 3) ? 0 : gen_ph + 1;
            if (gen_ph == 0) begin
                gen_ok     <= 1'b1;
                gen_data   <= gen_byte;
                gen_byte   <= gen_byte + 8'd1;
                force_full <= force_mode && (gen_byte == 8'd100);
            end else begin
                if (gen_ph >= gen_hold) gen_ok <= 1'b0;
                force_full <= 1'b0;
            end
        end
    end

    // FIFO: depth 256, registered read data.
    logic [7:0] fmem [256];
    int   f_wp = 0, f_rp = 0, f_cnt = 0;
    logic f_do_wr, f_do_rd;
    assign f_do_wr    = fifo_wr_en && (f_cnt < 256);
    assign f_do_rd    = fifo_rd_en && (f_cnt > 0);
    assign fifo_full  = (f_cnt == 256) || force_full;
    assign fifo_empty = (f_cnt == 0);

    always @(posedge sys_clk) begin
        if (fifo_clr) begin
            f_wp  <= 0;
            f_rp  <= 0;
            f_cnt <= 0;
        end else begin
            if (f_do_wr) begin
                fmem[f_wp] <= fifo_wr_data;
                f_wp       <= (f_wp + 1) % 256;
            end
            if (f_do_rd) begin
                fifo_rd_data <= fmem[f_rp];
                f_rp         <= (f_rp + 1) % 256;
            end
            f_cnt <= f_cnt + int'(f_do_wr) - int'(f_do_rd);
        end
    end

    // UART TX: busy for 10 cycles after each start, or never when u_noack is set.
    bit u_noack = 1'b0;
    int u_cnt   = 0;
    always @(posedge sys_clk) begin
        if (tx_start && !u_noack) begin
            tx_busy <= 1'b1;
            u_cnt   <= 10;
        end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) tx_busy <= 1'b0;
        end
    end

    // Monitor, sampled on the falling edge.
    logic [7:0] wr_log [4096];
    bit         wr_ge  [4096];
    logic [7:0] tx_log [4096];
    int         tx_cyc [4096];
    int cyc = 0, wr_n = 0, tx_n = 0, done_n = 0, clr_n = 0, done_cyc = 0;

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (fifo_wr_en && wr_n < 4096) begin
            wr_log[wr_n] <= fifo_wr_data;
            wr_ge[wr_n]  <= gen_en;
            wr_n         <= wr_n + 1;
        end
        if (tx_start && tx_n < 4096) begin
            tx_log[tx_n] <= tx_data;
            tx_cyc[tx_n] <= cyc;
            tx_n         <= tx_n + 1;
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (fifo_clr) clr_n <= clr_n + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k = 0;
        while (done_n == d0 && k < 8000) begin
            @(negedge sys_clk);
            k++;
        end
        check({tag, "_done_seen"}, int'(done_n != d0), 1);
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic chk_burst(input string tag, input int wb, input int tb0, input int db, input int cb,
                             input int skip, input int n_wr, input int e_err, input int e_wcnt,
                             input int e_scnt);
        int bad = 0;
        int mg  = 1000;
        check({tag, "_wr_n"}, wr_n - wb, n_wr);
        check({tag, "_tx_n"}, tx_n - tb0, e_scnt);
        for (int i = 0; i < n_wr && i < wr_n - wb; i++) begin
            int e = (skip >= 0 && i >= skip) ? i + 1 : i;
            if (int'(wr_log[wb + i]) != e) bad++;
        end
        for (int i = 0; i < e_scnt && i < tx_n - tb0; i++) begin
            int e = (skip >= 0 && i >= skip) ? i + 1 : i;
            if (int'(tx_log[tb0 + i]) != e) bad++;
            if (i > 0 && tx_cyc[tb0 + i] - tx_cyc[tb0 + i - 1] < mg) mg = tx_cyc[tb0 + i] - tx_cyc[tb0 + i - 1];
        end
        check({tag, "_order"}, bad, 0);
        check({tag, "_gap_ge4"}, int'(mg >= 4), 1);
        check({tag, "_done_n"}, done_n - db, 1);
        check({tag, "_clr_n"}, clr_n - cb, 1);
        check({tag, "_err"}, int'(err), e_err);
        check({tag, "_wr_cnt"}, int'(wr_cnt), e_wcnt);
        check({tag, "_sent_cnt"}, int'(sent_cnt), e_scnt);
        check({tag, "_busy_end"}, int'(busy), 0);
        if (wr_n > wb + 1) begin
            check({tag, "_gen_en_last_wr"}, int'(wr_ge[wr_n - 1]), 0);
            check({tag, "_gen_en_prev_wr"}, int'(wr_ge[wr_n - 2]), 1);
        end
    endtask

    int wb, tb0, db, cb, k;

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_flags", int'({gen_en, fifo_clr, fifo_wr_en, fifo_rd_en, tx_start, busy, done, err}), 0);
        check("rst_cnts", int'({wr_cnt, sent_cnt}), 0);
        check("rst_data", int'({tx_data, fifo_wr_data}), 0);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("idle_busy", int'(busy), 0);

        // 1: async reset in the middle of FILL
        pulse_start();
        k = 0;
        while (int'(wr_cnt) < 20 && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        check("t1_fill_busy", int'({busy, gen_en}), 3);
        sys_rst_n = 1'b0;
        #1;
        check("t1_rst_async", int'({gen_en, fifo_clr, fifo_wr_en, fifo_rd_en, tx_start, busy, done, err}), 0);
        k = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if ({gen_en, fifo_clr, fifo_wr_en, fifo_rd_en, tx_start, busy, done, err} != 10'd0 ||
                {wr_cnt, sent_cnt} != 18'd0) k++;
        end
        check("t1_rst_hold", k, 0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("t1_idle_after", int'({busy, gen_en, fifo_clr}), 0);
        check("t1_wr_cnt_after", int'(wr_cnt), 0);

        // 2: nominal burst
        gen_hold = 1;
        wb = wr_n; tb0 = tx_n; db = done_n; cb = clr_n;
        pulse_start();
        wait_done("t2", db);
        chk_burst("t2", wb, tb0, db, cb, -1, 256, 0, 256, 256);

        // 3: data_ok held two cycles per byte
        gen_hold = 2;
        wb = wr_n; tb0 = tx_n; db = done_n; cb = clr_n;
        pulse_start();
        wait_done("t3", db);
        chk_burst("t3", wb, tb0, db, cb, -1, 256, 0, 256, 256);

        // 4: FIFO full on the 101st byte
        gen_hold   = 1;
        force_mode = 1'b1;
        wb = wr_n; tb0 = tx_n; db = done_n; cb = clr_n;
        pulse_start();
        k = 0;
        while (tx_n == tb0 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        check("t4_err_after_fill", int'(err), 1);
        wait_done("t4", db);
        force_mode = 1'b0;
        chk_burst("t4", wb, tb0, db, cb, 100, 255, 3, 256, 255);

        // 5: UART never acknowledges
        u_noack = 1'b1;
        tb0 = tx_n; db = done_n;
        pulse_start();
        wait_done("t5", db);
        u_noack = 1'b0;
        check("t5_tx_n", tx_n - tb0, 1);
        check("t5_err", int'(err), 4);
        check("t5_sent_cnt", int'(sent_cnt), 1);
        check("t5_done_n", done_n - db, 1);
        check("t5_timeout_cycles", done_cyc - tx_cyc[tb0], 15);

        // 6: abort mid-drain, ignored starts, then a clean burst
        tb0 = tx_n; db = done_n; cb = clr_n;
        pulse_start();
        repeat (4) @(negedge sys_clk);
        check("t6_err_cleared", int'(err), 0);
        k = 0;
        while (tx_n - tb0 < 20 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        pulse_start();
        k = 0;
        while (int'(sent_cnt) != 40 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        check("t6_reach_40", int'(sent_cnt), 40);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("t6_abort_idle", int'({busy, gen_en}), 0);
        check("t6_abort_strobes", int'({fifo_clr, fifo_wr_en, fifo_rd_en, tx_start, done}), 0);
        repeat (30) @(negedge sys_clk);
        check("t6_no_done", done_n - db, 0);
        check("t6_start_ignored", clr_n - cb, 1);
        check("t6_tx_n", tx_n - tb0, 40);
        check("t6_sent_hold", int'(sent_cnt), 40);
        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("t6_abort_wins", int'(busy) + (clr_n - cb - 1), 0);
        wb = wr_n; tb0 = tx_n; db = done_n; cb = clr_n;
        pulse_start();
        wait_done("t6b", db);
        chk_burst("t6b", wb, tb0, db, cb, -1, 256, 0, 256, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
